btpipe_out_scheduler: RTL and testbench
=======================================

# btpipe_out_scheduler

Block-granular scheduler that shares one block-throttled pipe-out endpoint (address 0xA0 class) between several FPGA-side data sources. It sits between the source FIFOs and the `okBTPipeOut` endpoint on the `okClk` domain. It selects one source per block by round-robin, but only among sources holding a full block payload. It prefixes each block with a header word and streams the payload in step with the endpoint's read strobes.

## Interface
Parameters:
- N_SRC, 4 — number of sources (2..8).
- BLOCK_WORDS, 256 — 32-bit words per host block, header included (≥2).
- LEVEL_W, 16 — width of each source occupancy count.

Ports:
- clk  in  1  okClk.
- reset  in  1  asynchronous, active-high.
- enable  in  1  permits new grants.
- src_mask  in  N_SRC  per-source grant enable.
- src_level  in  N_SRC*LEVEL_W  words available per source (FWFT FIFOs).
- src_data  in  N_SRC*32  head word per source, valid while its level > 0.
- src_rd  out  N_SRC  pop strobe, one-hot or zero.
- pipe_out_read  in  1  endpoint read strobe.
- pipe_out_data  out  32  endpoint data (registered).
- pipe_out_ready  out  1  endpoint block-ready.
- busy  out  1  a block is granted (ARMED or XFER).
- active_src  out  3  index of granted source, valid while busy.
- blocks_sent  out  32  completed blocks, wraps.
- overrun_count  out  16  reads outside a block, saturates at 0xFFFF.

## Operation
- States: IDLE, ARMED, XFER.
- IDLE:
  - Source i is eligible when src_mask[i]=1 and src_level[i] ≥ BLOCK_WORDS-1.
  - If enable=1 and any source is eligible, grant the first eligible source after rr_ptr (cyclic).
  - On grant: latch the grant, set rr_ptr = grant index, go to ARMED.
- ARMED:
  - pipe_out_ready=1.
  - First pipe_out_read: load the header into pipe_out_data, go to XFER, word counter = 1.
- XFER:
  - pipe_out_ready=0.
  - Each pipe_out_read: pipe_out_data <= src_data[g], src_rd[g]=1 in the same cycle, counter++.
  - The read that makes the counter reach BLOCK_WORDS returns the FSM to IDLE, increments blocks_sent, and increments seq[g].
- Header word: {8'hA5, 5'b0, src index[2:0], seq[g][15:0]}.
  - seq[g] is a per-source 16-bit block counter, reset 0, wraps 0xFFFF→0.
- src_rd is combinational: (state==XFER) & pipe_out_read & grant.
  - The eligibility check guarantees the FIFO cannot underflow.
- pipe_out_read in IDLE: overrun_count increments (saturating); pipe_out_data holds.
- enable or src_mask deasserted mid-block: the block completes; only new grants are blocked.
- src_level changes during a block: ignored.
- Reset mid-block: all outputs return to their reset values immediately and the partial block is abandoned. Host-side recovery is the system reset.
- Reset values:
  - state IDLE, rr_ptr = N_SRC-1 (so source 0 is first priority).
  - pipe_out_data 0, pipe_out_ready 0, src_rd 0, busy 0, active_src 0.
  - blocks_sent 0, overrun_count 0, all seq 0.

## Timing
- Grant latency: eligible in IDLE at cycle t → state ARMED and pipe_out_ready=1 at t+1.
- Data latency: word k of the block appears on pipe_out_data in the cycle after the k-th pipe_out_read (k = 0..BLOCK_WORDS-1). Word 0 is the header.
- src_rd pulses in the same cycle as the read that consumes that word; src_data is sampled on that edge.
- Back-to-back reads are supported at one word per clock; gaps of any length are allowed.
- Last read at cycle t → IDLE at t+1 → next ARMED (pipe_out_ready=1) earliest at t+2.
- All outputs except src_rd are registered.

## Structure
- Package btpipe_sched_pkg holds:
  - state enum {IDLE, ARMED, XFER};
  - HDR_MAGIC = 8'hA5;
  - header field widths and a header-pack function.
- Sub-module rr_arbiter (N_SRC, req vector, last pointer in → one-hot grant and index out).
  - It is purely combinational; the pointer register lives in the scheduler.
- Word counter width is $clog2(BLOCK_WORDS+1).

## Test plan
- Single source: N_SRC=4, BLOCK_WORDS=4, src0 level 3 with data 0x11,0x22,0x33; issue 4 reads → pipe_out_data reads 0xA5000000, 0x11, 0x22, 0x33. src_rd[0] pulses on reads 2–4; blocks_sent=1.
- Round-robin: all four sources level 100, BLOCK_WORDS=4, 8 blocks read → source order 0,1,2,3,0,1,2,3. The second header from src2 is 0xA5020001.
- Eligibility: src1 level 2 (< 3), src3 level 3 → src3 granted; raising src1 to 3 → src1 wins the next arbitration after src3.
- Gated reads: reads spaced 1–5 cycles apart within a block → identical data sequence. pipe_out_ready is high only in ARMED.
- Overrun and enable: 5 reads with no eligible source → overrun_count=5, pipe_out_data unchanged. Dropping enable mid-block → the block finishes and no new ARMED state follows.
- Reset mid-XFER after 2 of 4 words: async reset asserted between edges → busy=0, pipe_out_ready=0, seq preserved at 0, next grant restarts at source 0.

Source files
------------

// File: rtl/btpipe_sched_pkg.sv
// Shared types, constants and header packing for the block pipe-out scheduler.
package btpipe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } sched_state_e;

    localparam logic [7:0]  HDR_MAGIC   = 8'hA5;
    localparam int unsigned HDR_MAGIC_W = 8;
    localparam int unsigned HDR_PAD_W   = 5;
    localparam int unsigned HDR_SRC_W   = 3;
    localparam int unsigned HDR_SEQ_W   = 16;
    localparam int unsigned WORD_W      = HDR_MAGIC_W + HDR_PAD_W + HDR_SRC_W + HDR_SEQ_W;

    // Header word prefixed to every block: magic, padding, source index, sequence.
    function automatic logic [WORD_W-1:0] hdr_pack(input logic [HDR_SRC_W-1:0] src,
                                                   input logic [HDR_SEQ_W-1:0] seq);
        return {HDR_MAGIC, HDR_PAD_W'(0), src, seq};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_ptr.
module rr_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic              found;
    logic [SEL_W-1:0]  sel;
    int unsigned       pos;

    // Walk the sources cyclically starting one past the last grant.
    always_comb begin
        grant     = '0;
        grant_idx = last_ptr;
        found     = 1'b0;
        sel       = '0;
        pos       = 0;
        for (int unsigned off = 1; off <= N_SRC; off++) begin
            pos = 32'(last_ptr) + off;
            if (pos >= N_SRC) pos = pos - N_SRC;
            sel = SEL_W'(pos);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/btpipe_out_scheduler.sv
// Block-granular round-robin scheduler feeding one block-throttled pipe-out endpoint.
module btpipe_out_scheduler
    import btpipe_sched_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned BLOCK_WORDS = 256,
    parameter int unsigned LEVEL_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_SRC-1:0]           src_mask,
    input  logic [N_SRC*LEVEL_W-1:0]   src_level,
    input  logic [N_SRC*32-1:0]        src_data,
    output logic [N_SRC-1:0]           src_rd,
    input  logic                       pipe_out_read,
    output logic [31:0]                pipe_out_data,
    output logic                       pipe_out_ready,
    output logic                       busy,
    output logic [2:0]                 active_src,
    output logic [31:0]                blocks_sent,
    output logic [15:0]                overrun_count
);

    localparam int unsigned SEL_W = $clog2(N_SRC);
    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);

    sched_state_e          state_q, state_d;
    logic [SEL_W-1:0]      rr_q, rr_d;
    logic [SEL_W-1:0]      gnt_q, gnt_d;
    logic [N_SRC-1:0]      gnt_oh_q, gnt_oh_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           blocks_q, blocks_d;
    logic [15:0]           ovr_q, ovr_d;
    logic                  ready_q, busy_q;
    logic [2:0]            active_q;
    logic [15:0]           seq_q [N_SRC];
    logic                  seq_inc;

    logic [LEVEL_W-1:0]    level_w [N_SRC];
    logic [31:0]           word_w  [N_SRC];
    logic [N_SRC-1:0]      eligible;
    logic [N_SRC-1:0]      arb_oh;
    logic [SEL_W-1:0]      arb_idx;

    // Unpack per-source buses and flag sources holding a full payload.
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign level_w[i]  = src_level[i*LEVEL_W +: LEVEL_W];
        assign word_w[i]   = src_data[i*32 +: 32];
        assign eligible[i] = src_mask[i] && (level_w[i] >= LEVEL_W'(BLOCK_WORDS - 1));
    end

    rr_arbiter #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_arb (
        .req       (eligible),
        .last_ptr  (rr_q),
        .grant     (arb_oh),
        .grant_idx (arb_idx)
    );

    // Next-state, datapath and counter updates.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        blocks_d = blocks_q;
        ovr_d    = ovr_q;
        seq_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pipe_out_read && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
                if (enable && (|eligible)) begin
                    gnt_d    = arb_idx;
                    gnt_oh_d = arb_oh;
                    rr_d     = arb_idx;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (pipe_out_read) begin
                    data_d  = hdr_pack(3'(gnt_q), seq_q[gnt_q]);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (pipe_out_read) begin
                    data_d = word_w[gnt_q];
                    cnt_d  = cnt_q + CNT_W'(1);
                    if ((cnt_q + CNT_W'(1)) == CNT_W'(BLOCK_WORDS)) begin
                        state_d  = ST_IDLE;
                        blocks_d = blocks_q + 32'd1;
                        seq_inc  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_q     <= SEL_W'(N_SRC - 1);
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            blocks_q <= '0;
            ovr_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            blocks_q <= blocks_d;
            ovr_q    <= ovr_d;
            ready_q  <= (state_d == ST_ARMED);
            busy_q   <= (state_d != ST_IDLE);
            active_q <= 3'(gnt_d);
        end
    end

    // Per-source block sequence numbers carried in the header.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SRC; i++) seq_q[i] <= '0;
        end else if (seq_inc) begin
            seq_q[gnt_q] <= seq_q[gnt_q] + 16'd1;
        end
    end

    // Pop strobe follows the endpoint read so the FIFO advances on the consuming edge.
    assign src_rd = (state_q == ST_XFER && pipe_out_read) ? gnt_oh_q : '0;

    assign pipe_out_data  = data_q;
    assign pipe_out_ready = ready_q;
    assign busy           = busy_q;
    assign active_src     = active_q;
    assign blocks_sent    = blocks_q;
    assign overrun_count  = ovr_q;

endmodule

// File: tb/tb_btpipe_out_scheduler.sv
// Directed bench for btpipe_out_scheduler with four counting FWFT source models.
module tb_btpipe_out_scheduler;

    localparam int unsigned NS = 4;
    localparam int unsigned BW = 4;
    localparam int unsigned LW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NS-1:0]     src_mask;
    logic [NS*LW-1:0]  src_level;
    logic [NS*32-1:0]  src_data;
    logic [NS-1:0]     src_rd;
    logic              pipe_out_read;
    logic [31:0]       pipe_out_data;
    logic              pipe_out_ready;
    logic              busy;
    logic [2:0]        active_src;
    logic [31:0]       blocks_sent;
    logic [15:0]       overrun_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pop_cnt [NS];

    btpipe_out_scheduler #(.N_SRC(NS), .BLOCK_WORDS(BW), .LEVEL_W(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .src_mask       (src_mask),
        .src_level      (src_level),
        .src_data       (src_data),
        .src_rd         (src_rd),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_ready (pipe_out_ready),
        .busy           (busy),
        .active_src     (active_src),
        .blocks_sent    (blocks_sent),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    // Source FIFO model: head word of source i after p pops is 0x11*(p+1) + i*0x1000.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) pop_cnt[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NS; i++) if (src_rd[i]) pop_cnt[i] <= pop_cnt[i] + 32'd1;
        end
    end

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NS; i++)
            src_data[i*32 +: 32] = 32'h11 * (pop_cnt[i] + 32'd1) + 32'(i) * 32'h1000;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_levels(input logic [15:0] l0, input logic [15:0] l1,
                              input logic [15:0] l2, input logic [15:0] l3);
        src_level = {l3, l2, l1, l0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One endpoint read issued at a negedge; returns data seen next negedge and the pop strobe.
    task automatic rd(input int gap, output logic [31:0] d, output logic [NS-1:0] rds);
        pipe_out_read = 1'b1;
        #1 rds = src_rd;
        @(negedge clk);
        pipe_out_read = 1'b0;
        d = pipe_out_data;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!pipe_out_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(pipe_out_ready), 32'd1);
    endtask

    // Reads a whole block back-to-back, checking header and final payload word.
    task automatic do_block(input string tag, input logic [31:0] exp_hdr, input logic [31:0] exp_last);
        logic [31:0]   d;
        logic [NS-1:0] r;
        rd(0, d, r);
        check({tag, "_hdr"}, d, exp_hdr);
        for (int k = 1; k < BW; k++) rd(0, d, r);
        check({tag, "_last"}, d, exp_last);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0]   d;
        logic [NS-1:0] r;
        reset         = 1'b1;
        enable        = 1'b0;
        src_mask      = '0;
        src_level     = '0;
        pipe_out_read = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_data",   pipe_out_data, 32'h0);
        check("rst_ready",  32'(pipe_out_ready), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_active", 32'(active_src), 32'd0);
        check("rst_blocks", blocks_sent, 32'd0);
        check("rst_ovr",    32'(overrun_count), 32'd0);
        check("rst_srcrd",  32'(src_rd), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single source, four words
        set_levels(16'd3, 16'd0, 16'd0, 16'd0);
        src_mask = 4'b0001;
        enable   = 1'b1;
        wait_ready("t1_ready");
        enable = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        rd(0, d, r); check("t1_w0", d, 32'hA500_0000); check("t1_rd0", 32'(r), 32'h0);
        rd(0, d, r); check("t1_w1", d, 32'h0000_0011); check("t1_rd1", 32'(r), 32'h1);
        check("t1_rdy_xfer", 32'(pipe_out_ready), 32'd0);
        rd(0, d, r); check("t1_w2", d, 32'h0000_0022); check("t1_rd2", 32'(r), 32'h1);
        rd(0, d, r); check("t1_w3", d, 32'h0000_0033); check("t1_rd3", 32'(r), 32'h1);
        check("t1_blocks", blocks_sent, 32'd1);
        repeat (2) @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Round-robin over four full sources
        do_reset();
        set_levels(16'd100, 16'd100, 16'd100, 16'd100);
        src_mask = 4'b1111;
        enable   = 1'b1;
        for (int b = 0; b < 8; b++) begin
            wait_ready($sformatf("t2_ready%0d", b));
            check($sformatf("t2_src%0d", b), 32'(active_src), 32'(b % 4));
            if (b == 7) enable = 1'b0;
            do_block($sformatf("t2_b%0d", b),
                     32'hA500_0000 | (32'(b % 4) << 16) | 32'(b / 4),
                     32'h11 * 32'(3 * (b / 4) + 3) + 32'(b % 4) * 32'h1000);
        end
        check("t2_blocks", blocks_sent, 32'd8);

        // Eligibility threshold
        do_reset();
        set_levels(16'd0, 16'd2, 16'd0, 16'd3);
        enable = 1'b1;
        wait_ready("t3_ready_a");
        check("t3_src_a", 32'(active_src), 32'd3);
        set_levels(16'd0, 16'd3, 16'd0, 16'd3);
        do_block("t3_a", 32'hA503_0000, 32'h0000_3033);
        wait_ready("t3_ready_b");
        check("t3_src_b", 32'(active_src), 32'd1);
        enable = 1'b0;
        do_block("t3_b", 32'hA501_0000, 32'h0000_1033);

        // Gated reads with uneven spacing
        set_levels(16'd0, 16'd0, 16'd3, 16'd0);
        src_mask = 4'b0100;
        enable   = 1'b1;
        wait_ready("t4_ready");
        enable = 1'b0;
        rd(1, d, r); check("t4_w0", d, 32'hA502_0000);
        check("t4_rdy_gap", 32'(pipe_out_ready), 32'd0);
        check("t4_busy_gap", 32'(busy), 32'd1);
        rd(3, d, r); check("t4_w1", d, 32'h0000_2011);
        rd(5, d, r); check("t4_w2", d, 32'h0000_2022);
        rd(2, d, r); check("t4_w3", d, 32'h0000_2033);

        // Overruns with nothing eligible, then enable dropped mid-block
        set_levels(16'd0, 16'd0, 16'd0, 16'd0);
        src_mask = 4'b0000;
        enable   = 1'b1;
        for (int k = 0; k < 5; k++) rd(0, d, r);
        check("t5_ovr", 32'(overrun_count), 32'd5);
        check("t5_hold", pipe_out_data, 32'h0000_2033);
        set_levels(16'd3, 16'd0, 16'd0, 16'd0);
        src_mask = 4'b0001;
        wait_ready("t5_ready");
        rd(0, d, r); check("t5_w0", d, 32'hA500_0000);
        enable = 1'b0;
        for (int k = 1; k < BW; k++) rd(0, d, r);
        check("t5_w3", d, 32'h0000_0033);
        repeat (5) @(negedge clk);
        check("t5_no_rearm", 32'(pipe_out_ready), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_blocks", blocks_sent, 32'd4);

        // Reset in the middle of a block
        set_levels(16'd3, 16'd3, 16'd3, 16'd3);
        src_mask = 4'b1111;
        enable   = 1'b1;
        wait_ready("t6_ready_a");
        check("t6_src_a", 32'(active_src), 32'd1);
        rd(0, d, r); check("t6_w0", d, 32'hA501_0001);
        rd(0, d, r); check("t6_w1", d, 32'h0000_1044);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(pipe_out_ready), 32'd0);
        check("t6_data", pipe_out_data, 32'h0);
        check("t6_blocks", blocks_sent, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready("t6_ready_b");
        check("t6_src_b", 32'(active_src), 32'd0);
        enable = 1'b0;
        do_block("t6_b", 32'hA500_0000, 32'h0000_0033);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
